// File: rtl/array_sort_check_control_if.sv
// Interface: array_sort_check_control_if
// Bundles the request, datapath status and control/result signals of the
// array sort-check controller.
//   master  : controller side. It reads go, the flags and index, and drives the
//             strobes and the result signals.
//   slave   : datapath/requester side, with the directions reversed.
// Signals:
//   go                 start request (level)
//   inversion_found    datapath: A[index] > A[index+1]
//   end_of_array       datapath: index is the last compare position
//   zero_length_array  datapath: length == 0
//   index              datapath index register value
//   load_input         latch array base and length
//   load_index         write the index register
//   select_index       index mux: 0 = load 0, 1 = load index+1
//   busy / done / sorted, fail_index, check_cycles  run status and results
interface array_sort_check_control_if #(
    parameter int IDX_WIDTH = 5,
    parameter int CNT_WIDTH = 8
);
    logic                 go;
    logic                 inversion_found;
    logic                 end_of_array;
    logic                 zero_length_array;
    logic [IDX_WIDTH-1:0] index;
    logic                 load_input;
    logic                 load_index;
    logic                 select_index;
    logic                 busy;
    logic                 done;
    logic                 sorted;
    logic [IDX_WIDTH-1:0] fail_index;
    logic [CNT_WIDTH-1:0] check_cycles;

    modport master (
        input  go, inversion_found, end_of_array, zero_length_array, index,
        output load_input, load_index, select_index,
        output busy, done, sorted, fail_index, check_cycles
    );

    modport slave (
        output go, inversion_found, end_of_array, zero_length_array, index,
        input  load_input, load_index, select_index,
        input  busy, done, sorted, fail_index, check_cycles
    );
endinterface

// File: rtl/array_sort_check_control.sv
// Module: array_sort_check_control
// Control FSM for the array sort-check datapath. It turns a level go request
// into the load_input/load_index/select_index strobes, walks the datapath index
// until a terminating flag appears, and reports done/sorted, the index of the
// first inversion and the number of cycles spent checking.
// Ports:
//   clock  system clock, rising edge
//   reset  asynchronous, active-low reset
//   bus    array_sort_check_control_if.master (request, flags, strobes, results)
module array_sort_check_control #(
    parameter int IDX_WIDTH = 5,
    parameter int CNT_WIDTH = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    array_sort_check_control_if.master    bus
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        SORTED,
        UNSORTED
    } state_t;

    state_t               state;
    logic [IDX_WIDTH-1:0] fail_index;
    logic [CNT_WIDTH-1:0] check_cycles;
    logic                 terminate;

    // Any of the three flags ends the run; used to freeze the index on the
    // final compare.
    assign terminate = bus.zero_length_array | bus.inversion_found | bus.end_of_array;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            fail_index   <= '0;
            check_cycles <= '0;
        end else begin
            case (state)
                IDLE, SORTED, UNSORTED: begin
                    if (bus.go) state <= LOAD;
                end
                LOAD: begin
                    // Inputs keep reloading while go is held; the run starts
                    // on the falling edge of go with fresh results.
                    if (!bus.go) begin
                        state        <= CHECK;
                        fail_index   <= '0;
                        check_cycles <= '0;
                    end
                end
                CHECK: begin
                    // Counts every CHECK edge including the terminating one,
                    // saturating instead of wrapping.
                    if (check_cycles != '1) check_cycles <= check_cycles + 1'b1;
                    // Zero length wins over a spurious inversion; an inversion
                    // wins over end_of_array on the same compare.
                    if (bus.zero_length_array) begin
                        state <= SORTED;
                    end else if (bus.inversion_found) begin
                        state      <= UNSORTED;
                        fail_index <= bus.index;
                    end else if (bus.end_of_array) begin
                        state <= SORTED;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes are combinational from state and inputs. They are also gated by
    // reset so that nothing reaches the datapath while reset is held, even
    // though go can be high in IDLE.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned, which would infer a latch.
        bus.load_input   = 1'b0;
        bus.load_index   = 1'b0;
        bus.select_index = 1'b0;
        if (reset) begin
            case (state)
                LOAD: begin
                    bus.load_input = 1'b1;
                    bus.load_index = 1'b1;
                end
                CHECK: begin
                    bus.select_index = 1'b1;
                    bus.load_index   = !terminate;
                end
                default: begin
                    bus.load_input = bus.go;
                    bus.load_index = bus.go;
                end
            endcase
        end
    end

    // Status outputs are pure decodes of the state register.
    assign bus.busy         = (state == LOAD) || (state == CHECK);
    assign bus.done         = (state == SORTED) || (state == UNSORTED);
    assign bus.sorted       = (state == SORTED);
    assign bus.fail_index   = fail_index;
    assign bus.check_cycles = check_cycles;

endmodule
